// File: rtl/mul_defs.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// iteration count and counter width.
package mul_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 5;

  // True on the final EXEC iteration, the one that hands over to DONE.
  function automatic logic last_iter(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(ITERS - 1);
  endfunction

endpackage

// File: rtl/cla32_ov.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups, exposing the
// carry out of bit 31 (co) and the carry into bit 31 (co_prev).
module cla32_ov (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co,
  output logic        co_prev
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = ci;

  // Each group resolves its four internal carries directly from the group carry-in.
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = gi * 4;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign sum     = p ^ c[31:0];
  assign co      = c[32];
  assign co_prev = c[31];

endmodule

// File: rtl/mul32_seq.sv
// Unsigned 32x32 -> 64 sequential shift-add multiplier, one partial product per
// clock over 32 EXEC cycles, with synchronous abort and a held result register.
module mul32_seq
  import mul_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      m_q, m_d;
  logic [31:0]      p_hi_q, p_hi_d;
  logic [31:0]      p_lo_q, p_lo_d;
  logic [63:0]      result_q, result_d;

  logic [31:0] addend;
  logic [31:0] add_sum;
  logic        add_co;
  logic [63:0] p_shifted;

  assign addend = p_lo_q[0] ? m_q : 32'd0;

  cla32_ov u_add (
    .a       (p_hi_q),
    .b       (addend),
    .ci      (1'b0),
    .sum     (add_sum),
    .co      (add_co),
    .co_prev ()
  );

  // The carry becomes the new MSB, so nothing is lost across iterations.
  assign p_shifted = {add_co, add_sum, p_lo_q[31:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    result_d = result_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_d     = mcand;
            p_hi_d  = 32'd0;
            p_lo_d  = mplier;
            cnt_d   = '0;
            state_d = EXEC;
          end
        end
        EXEC: begin
          p_hi_d = p_shifted[63:32];
          p_lo_d = p_shifted[31:0];
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_iter(cnt_q)) begin
            result_d = p_shifted;
            state_d  = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_q      <= 32'd0;
      p_hi_q   <= 32'd0;
      p_lo_q   <= 32'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == EXEC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Randomised self-checking bench for mul32_seq against a plain 64-bit product
// model, including mid-operation start, clear and reset cases.
module tb_mul32_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        clear;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_res;

  localparam int LAT = 32;

  mul32_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .clear   (clear),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h want=0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // One full operation. poke >= 0 pulses start with fresh operands at that EXEC cycle.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int poke);
    int e;
    int busy_n;
    int unstable;
    logic [63:0] exp;
    exp = ref_mul(a, b);
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; mcand = $urandom; mplier = $urandom;
    e = 0; busy_n = 0; unstable = 0;
    while (!done && e < 100) begin
      if (busy) busy_n++;
      if (result !== last_res) unstable++;
      if (e == poke) begin
        start = 1'b1; mcand = $urandom; mplier = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 64'(e), 64'(LAT));
    chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(LAT));
    chk({tag, ".result_held"}, 64'(unstable), 64'd0);
    chk({tag, ".result"}, result, exp);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, ".result_after"}, result, exp);
    $display("op %s: %08h * %08h = %016h (cycles=%0d)", tag, a, b, result, e);
    last_res = exp;
  endtask

  // Counts done pulses over n cycles.
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int dn;
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; mcand = '0; mplier = '0;
    last_res = 64'd0;
    repeat (3) @(negedge clk);
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.result", result, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op("3x5", 32'd3, 32'd5, -1);
    chk("3x5.const", result, 64'h0000_0000_0000_000F);
    do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("max.const", result, 64'hFFFF_FFFE_0000_0001);
    do_op("zero", 32'h1234_5678, 32'h0, -1);
    do_op("msb", 32'h1234_5678, 32'h8000_0000, -1);
    chk("msb.const", result, 64'h091A_2B3C_0000_0000);
    do_op("poke", 32'hDEAD_BEEF, 32'h0BAD_F00D, 10);

    // Reset in the middle of EXEC abandons the operation.
    @(negedge clk);
    mcand = 32'd9; mplier = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.busy", {63'd0, busy}, 64'd0);
    chk("rst_mid.done", {63'd0, done}, 64'd0);
    chk("rst_mid.result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    count_done(40, dn);
    chk("rst_mid.no_done", 64'(dn), 64'd0);
    $display("op rst_mid: outputs cleared, done pulses after release=%0d", dn);
    last_res = 64'd0;
    do_op("7x6", 32'd7, 32'd6, -1);
    chk("7x6.const", result, 64'd42);

    // Clear at EXEC cycle 5 keeps the previous result.
    @(negedge clk);
    mcand = $urandom; mplier = $urandom; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clear.busy", {63'd0, busy}, 64'd0);
    chk("clear.done", {63'd0, done}, 64'd0);
    chk("clear.result", result, 64'd42);
    @(negedge clk);
    clear = 1'b0;
    count_done(40, dn);
    chk("clear.no_done", 64'(dn), 64'd0);
    chk("clear.result_kept", result, 64'd42);
    $display("op clear: result kept=%0d, done pulses=%0d", result, dn);

    // start and clear together in IDLE: clear wins.
    @(negedge clk);
    mcand = 32'd11; mplier = 32'd13; start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    chk("sc.busy", {63'd0, busy}, 64'd0);
    count_done(40, dn);
    chk("sc.no_done", 64'(dn), 64'd0);
    chk("sc.result", result, 64'd42);
    $display("op start+clear: ignored, result=%0d", result);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = 32'hFFFF_FFFF;
      if (i % 4 == 2) b = 32'd1 << $urandom_range(31, 0);
      do_op($sformatf("rnd%0d", i), a, b, (i % 3 == 0) ? int'($urandom_range(30, 0)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
